// File: rtl/cs_measurement_accumulator.sv
// rtl/cs_measurement_accumulator.sv - Bernoulli +/-1 compressive-sensing measurement accumulator; optional CS_SEED_LOAD_EN seed port
module cs_measurement_accumulator #(
    parameter int          N_SAMPLES = 256,
    parameter int          M_MEAS    = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_5EED,
    localparam int         ACC_W     = 9 + $clog2(N_SAMPLES),
    localparam int         IDX_W     = (M_MEAS > 1) ? $clog2(M_MEAS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic [ACC_W-1:0] meas_out,
    output logic [IDX_W-1:0] meas_idx,
    output logic             meas_valid,
    input  logic             meas_ready,
`ifdef CS_SEED_LOAD_EN
    input  logic [31:0]      seed_in,
    input  logic             seed_wr,
`endif
    output logic             frame_done
);

    localparam int          CNT_W    = $clog2(N_SAMPLES);
    localparam logic [31:0] TAP_MASK = 32'h8020_0003;
    localparam logic [0:0]  ST_ACCUM = 1'b0;
    localparam logic [0:0]  ST_DRAIN = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        count;
    logic [31:0]             lfsr;
    logic [31:0]             lfsr_next;
    logic [31:0]             frame_seed;
    logic signed [ACC_W-1:0] acc     [M_MEAS];
    logic signed [ACC_W-1:0] acc_upd [M_MEAS];
    logic signed [ACC_W-1:0] sample_ext;
    logic                    accept;
    logic                    last_sample;
    logic                    last_idx;
    logic [IDX_W-1:0]        idx_next;

`ifdef CS_SEED_LOAD_EN
    logic [31:0] seed_reg;

    // Writes land in seed_reg only; the LFSR picks it up at the next frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_reg <= LFSR_SEED;
        end else if (seed_wr && (seed_in != 32'd0)) begin
            seed_reg <= seed_in;
        end
    end

    assign frame_seed = seed_reg;
`else
    assign frame_seed = LFSR_SEED;
`endif

    assign sample_ready = (state == ST_ACCUM);
    assign meas_valid   = (state == ST_DRAIN);
    assign accept       = sample_valid && sample_ready;
    assign last_sample  = (count == CNT_W'(N_SAMPLES - 1));
    assign last_idx     = (meas_idx == IDX_W'(M_MEAS - 1));
    assign idx_next     = meas_idx + 1'b1;
    assign frame_done   = meas_valid && meas_ready && last_idx;
    assign lfsr_next    = (lfsr >> 1) ^ (lfsr[0] ? TAP_MASK : 32'd0);
    assign sample_ext   = $signed({{(ACC_W - 8){1'b0}}, sample_in});

    always_comb begin
        for (int j = 0; j < M_MEAS; j++) begin
            acc_upd[j] = lfsr[j] ? (acc[j] + sample_ext) : (acc[j] - sample_ext);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_ACCUM;
            count    <= '0;
            lfsr     <= LFSR_SEED;
            meas_out <= '0;
            meas_idx <= '0;
            for (int j = 0; j < M_MEAS; j++) begin
                acc[j] <= '0;
            end
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        for (int j = 0; j < M_MEAS; j++) begin
                            acc[j] <= acc_upd[j];
                        end
                        lfsr <= lfsr_next;
                        if (last_sample) begin
                            count    <= '0;
                            state    <= ST_DRAIN;
                            // Measurement 0 must be valid in the first drain cycle.
                            meas_out <= acc_upd[0];
                            meas_idx <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (meas_ready) begin
                        if (last_idx) begin
                            state    <= ST_ACCUM;
                            count    <= '0;
                            lfsr     <= frame_seed;
                            meas_idx <= '0;
                            meas_out <= '0;
                            for (int j = 0; j < M_MEAS; j++) begin
                                acc[j] <= '0;
                            end
                        end else begin
                            meas_idx <= idx_next;
                            meas_out <= acc[idx_next];
                        end
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule
